multi_cycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the simple MIPS-style CPU datapath (PC, instruction memory, register file, ALU).
- Walks each instruction through FETCH / DECODE / EXEC / WB or BRANCH.
- Drives every datapath strobe and mux select, and handshakes with a variable-latency instruction memory.
- Supports opcodes RTYPE 000000, ADDI 001000, BEQ 000100, ORI 001101, LUI 001111; funct decoding stays in the ALU control.

---
 rtl/cpu_ctrl_pkg.sv | 88 ++++++++
 rtl/ctrl_fetch_timer.sv | 50 +++++
 rtl/multi_cycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multi-cycle control sequencer:
//   - supported opcode constants (OP_*)
//   - sequencer state encoding (state_e)
//   - ALU operation and immediate-extension select codes (ALU_OP_*, EXT_*)
//   - alu_ctrl_for(): per-opcode ALU/datapath select bundle used in EXEC and WB
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // Encoding 3'd7 is deliberately left unused; the next-state logic maps it to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] ext_sel;
    logic [1:0] alu_op;
  } alu_ctrl_t;

  // True for opcodes that go through EXEC/WB (register-writing ALU instructions).
  function automatic logic is_alu_type(input logic [5:0] op);
    logic r;
    case (op)
      OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  // Datapath selects for an ALU-type opcode; unknown opcodes yield all zeros.
  function automatic alu_ctrl_t alu_ctrl_for(input logic [5:0] op);
    alu_ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst = 1'b1;
        c.alu_src = 1'b0;
        c.ext_sel = EXT_SIGN;
        c.alu_op  = ALU_OP_FUNCT;
      end
      OP_ADDI: begin
        c.reg_dst = 1'b0;
        c.alu_src = 1'b1;
        c.ext_sel = EXT_SIGN;
        c.alu_op  = ALU_OP_ADD;
      end
      OP_ORI: begin
        c.reg_dst = 1'b0;
        c.alu_src = 1'b1;
        c.ext_sel = EXT_ZERO;
        c.alu_op  = ALU_OP_OR;
      end
      OP_LUI: begin
        c.reg_dst = 1'b0;
        c.alu_src = 1'b1;
        c.ext_sel = EXT_LUI;
        c.alu_op  = ALU_OP_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_fetch_timer.sv
// -----------------------------------------------------------------------------
// ctrl_fetch_timer
// Counts consecutive FETCH cycles spent waiting for instruction memory and
// flags the cycle in which the wait budget is used up.
// Parameters:
//   FETCH_TIMEOUT  number of FETCH cycles allowed before trapping (1..255)
// Ports:
//   clk_i       in   clock, rising edge
//   rst_i       in   synchronous active-high reset
//   in_fetch_i  in   sequencer is in FETCH this cycle
//   ack_i       in   instruction memory acknowledged this cycle
//   expire_o    out  this is the FETCH_TIMEOUT-th FETCH cycle (combinational)
// -----------------------------------------------------------------------------
module ctrl_fetch_timer #(
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_fetch_i,
  input  logic ack_i,
  output logic expire_o
);

  // Counter holds (FETCH cycle index - 1), so it never exceeds FETCH_TIMEOUT-1.
  localparam int CW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(FETCH_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Timeout compare and next count; the count clears whenever FETCH is left.
  always_comb begin
    expire_o = in_fetch_i && (cnt_q == LAST);
    if (in_fetch_i && !ack_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Wait-counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
// Multi-cycle control sequencer for a MIPS-style datapath. Walks each
// instruction through FETCH / DECODE / EXEC / WB (ALU types) or
// FETCH / DECODE / BRANCH (BEQ), trapping on fetch timeout or illegal opcode.
// Build option:
//   MULTI_CYCLE_CTRL_PERF_CNT_EN  when defined, retired_o counts instructions
//                                 leaving WB or BRANCH; otherwise it is tied 0.
// Parameters: FETCH_TIMEOUT (1..255), CNT_W (retired counter width)
// Ports:
//   clk_i, rst_i (sync, active-high), start_i, stop_i, op_i[5:0], zero_i,
//   imem_ack_i                                       -- inputs
//   imem_req_o, ir_write_o, pc_write_o, pc_src_o, reg_write_o, reg_dst_o,
//   alu_src_o, ext_sel_o[1:0], alu_op_o[1:0]         -- datapath strobes/selects
//   busy_o, trap_o, state_o[2:0], retired_o[CNT_W-1:0] -- status
// -----------------------------------------------------------------------------
module multi_cycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 15,
  parameter int CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [5:0]       op_i,
  input  logic             zero_i,
  input  logic             imem_ack_i,
  output logic             imem_req_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             alu_src_o,
  output logic [1:0]       ext_sel_o,
  output logic [1:0]       alu_op_o,
  output logic             busy_o,
  output logic             trap_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e    state_q;
  state_e    state_d;
  logic      ack_s;
  logic      expire_s;
  alu_ctrl_t alu_ctrl_s;

  // An ack arriving while reset is asserted must not load IR or bump PC.
  assign ack_s      = imem_ack_i & ~rst_i;
  assign alu_ctrl_s = alu_ctrl_for(op_i);
  assign state_o    = state_q;

  ctrl_fetch_timer #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_fetch_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_fetch_i(state_q == ST_FETCH),
    .ack_i     (ack_s),
    .expire_o  (expire_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ack beats timeout, stop beats start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) state_d = ST_FETCH;
        else                    state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (ack_s)         state_d = ST_DECODE;
        else if (expire_s) state_d = ST_TRAP;
        else               state_d = ST_FETCH;
      end
      ST_DECODE: begin
        if (is_alu_type(op_i))    state_d = ST_EXEC;
        else if (op_i == OP_BEQ)  state_d = ST_BRANCH;
        else                      state_d = ST_TRAP;
      end
      ST_EXEC:           state_d = ST_WB;
      ST_WB, ST_BRANCH: begin
        if (stop_i) state_d = ST_IDLE;
        else        state_d = ST_FETCH;
      end
      ST_TRAP:           state_d = ST_TRAP;
      default:           state_d = ST_IDLE;
    endcase
  end

  // Output decode: Moore on state/op, except fetch ack pulses and branch PC write.
  always_comb begin
    imem_req_o  = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = 1'b0;
    reg_write_o = 1'b0;
    reg_dst_o   = 1'b0;
    alu_src_o   = 1'b0;
    ext_sel_o   = EXT_SIGN;
    alu_op_o    = ALU_OP_ADD;
    busy_o      = 1'b0;
    trap_o      = 1'b0;
    case (state_q)
      ST_IDLE: busy_o = 1'b0;
      ST_FETCH: begin
        busy_o     = 1'b1;
        imem_req_o = 1'b1;
        if (ack_s) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
        end else begin
          ir_write_o = 1'b0;
          pc_write_o = 1'b0;
        end
      end
      ST_DECODE: busy_o = 1'b1;
      // WB keeps the EXEC selects so the ALU result stays stable while written.
      ST_EXEC, ST_WB: begin
        busy_o      = 1'b1;
        reg_dst_o   = alu_ctrl_s.reg_dst;
        alu_src_o   = alu_ctrl_s.alu_src;
        ext_sel_o   = alu_ctrl_s.ext_sel;
        alu_op_o    = alu_ctrl_s.alu_op;
        reg_write_o = (state_q == ST_WB);
      end
      // PC already holds PC+4 from FETCH, so the taken target is PC+(sext(imm)<<2).
      ST_BRANCH: begin
        busy_o     = 1'b1;
        alu_op_o   = ALU_OP_SUB;
        pc_write_o = zero_i;
        pc_src_o   = zero_i;
      end
      ST_TRAP: trap_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

`ifdef MULTI_CYCLE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] retired_d;

  // Count an instruction as it leaves WB or BRANCH (both always exit after one cycle).
  always_comb begin
    if (state_q == ST_WB || state_q == ST_BRANCH) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_o = retired_q;
`else
  assign retired_o = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_ctrl
// Directed self-checking bench for multi_cycle_ctrl (FETCH_TIMEOUT=15).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_ORI   = 6'b001101;
  localparam logic [5:0] T_BAD   = 6'b100011;

`ifdef MULTI_CYCLE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, stop, zero, ack;
  logic [5:0]  op;
  logic        imem_req, ir_write, pc_write, pc_src, reg_write, reg_dst, alu_src;
  logic [1:0]  ext_sel, alu_op;
  logic        busy, trap;
  logic [2:0]  state;
  logic [31:0] retired;
  logic [12:0] ctl;

  int n_checks = 0;
  int n_fail   = 0;
  int ret_cnt  = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.FETCH_TIMEOUT(15), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .op_i(op),
    .zero_i(zero), .imem_ack_i(ack), .imem_req_o(imem_req), .ir_write_o(ir_write),
    .pc_write_o(pc_write), .pc_src_o(pc_src), .reg_write_o(reg_write),
    .reg_dst_o(reg_dst), .alu_src_o(alu_src), .ext_sel_o(ext_sel),
    .alu_op_o(alu_op), .busy_o(busy), .trap_o(trap), .state_o(state),
    .retired_o(retired)
  );

  assign ctl = {imem_req, ir_write, pc_write, pc_src, reg_write, reg_dst,
                alu_src, ext_sel, alu_op, busy, trap};

  function automatic logic [12:0] pk(input logic req, input logic irw, input logic pcw,
                                     input logic pcs, input logic rw, input logic rd,
                                     input logic as, input logic [1:0] ext,
                                     input logic [1:0] aop, input logic bsy,
                                     input logic trp);
    return {req, irw, pcw, pcs, rw, rd, as, ext, aop, bsy, trp};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ret(input string tag);
    check_eq(tag, retired, PERF ? 32'(ret_cnt) : 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; zero = 1'b0; ack = 1'b1; op = 6'd0;
    tick(); tick();
    check_eq("reset_state", 32'(state), 32'd0);
    check_eq("reset_ctl", 32'(ctl), 32'd0);
    check_ret("reset_retired");
    rst = 1'b0; ack = 1'b0;

    // ADDI: 1,2,3,4,1
    start = 1'b1; #1;
    check_eq("idle_before_start", 32'(state), 32'd0);
    tick(); start = 1'b0;
    op = T_ADDI; ack = 1'b1; #1;
    check_eq("fetch_state", 32'(state), 32'd1);
    check_eq("fetch_ack_ctl", 32'(ctl), 32'(pk(1,1,1,0,0,0,0,2'b00,2'b00,1,0)));
    tick(); ack = 1'b0; #1;
    check_eq("decode_state", 32'(state), 32'd2);
    check_eq("decode_ctl", 32'(ctl), 32'(pk(0,0,0,0,0,0,0,2'b00,2'b00,1,0)));
    tick();
    check_eq("addi_exec_state", 32'(state), 32'd3);
    check_eq("addi_exec_ctl", 32'(ctl), 32'(pk(0,0,0,0,0,0,1,2'b00,2'b00,1,0)));
    tick();
    check_eq("addi_wb_state", 32'(state), 32'd4);
    check_eq("addi_wb_ctl", 32'(ctl), 32'(pk(0,0,0,0,1,0,1,2'b00,2'b00,1,0)));
    tick(); ret_cnt = 1;
    check_eq("addi_next_fetch", 32'(state), 32'd1);
    check_eq("addi_no_ack_ctl", 32'(ctl), 32'(pk(1,0,0,0,0,0,0,2'b00,2'b00,1,0)));
    check_ret("retired_1");

    // BEQ taken
    op = T_BEQ; ack = 1'b1; tick(); ack = 1'b0; zero = 1'b1; tick();
    check_eq("beq_t_state", 32'(state), 32'd5);
    check_eq("beq_taken_ctl", 32'(ctl), 32'(pk(0,0,1,1,0,0,0,2'b00,2'b01,1,0)));
    tick(); ret_cnt = 2;
    check_eq("beq_t_next", 32'(state), 32'd1);

    // BEQ not taken
    ack = 1'b1; tick(); ack = 1'b0; zero = 1'b0; tick();
    check_eq("beq_nt_ctl", 32'(ctl), 32'(pk(0,0,0,0,0,0,0,2'b00,2'b01,1,0)));
    tick(); ret_cnt = 3;
    check_eq("beq_nt_next", 32'(state), 32'd1);

    // Two more ADDI, stop raised in the WB of the last one
    op = T_ADDI; ack = 1'b1; tick(); ack = 1'b0; tick(); tick(); tick(); ret_cnt = 4;
    ack = 1'b1; tick(); ack = 1'b0; tick(); tick();
    check_eq("addi5_wb", 32'(state), 32'd4);
    stop = 1'b1; tick(); ret_cnt = 5;
    check_eq("stop_to_idle", 32'(state), 32'd0);
    check_eq("idle_not_busy", 32'(busy), 32'd0);
    check_ret("perf_five");
    stop = 1'b0;

    // ORI with stop raised during EXEC
    start = 1'b1; tick(); start = 1'b0;
    op = T_ORI; ack = 1'b1; tick(); ack = 1'b0; tick();
    stop = 1'b1; #1;
    check_eq("ori_exec_ctl", 32'(ctl), 32'(pk(0,0,0,0,0,0,1,2'b01,2'b11,1,0)));
    tick();
    check_eq("stop_ignored_exec", 32'(state), 32'd4);
    check_eq("ori_wb_ctl", 32'(ctl), 32'(pk(0,0,0,0,1,0,1,2'b01,2'b11,1,0)));
    tick(); ret_cnt = 6;
    check_eq("ori_stop_idle", 32'(state), 32'd0);
    check_eq("ori_idle_busy", 32'(busy), 32'd0);

    // start and stop together keep IDLE
    start = 1'b1; tick(); tick();
    check_eq("start_stop_idle", 32'(state), 32'd0);
    start = 1'b0; stop = 1'b0;

    // RTYPE
    start = 1'b1; tick(); start = 1'b0;
    op = T_RTYPE; ack = 1'b1; tick(); ack = 1'b0; tick();
    check_eq("rtype_exec_ctl", 32'(ctl), 32'(pk(0,0,0,0,0,1,0,2'b00,2'b10,1,0)));
    tick(); tick(); ret_cnt = 7;
    check_ret("retired_7");

    // Ack on the 15th FETCH cycle still wins over the timeout
    for (int i = 0; i < 14; i++) tick();
    check_eq("fetch_cycle15_state", 32'(state), 32'd1);
    check_eq("fetch_cycle15_trap", 32'(trap), 32'd0);
    op = T_BAD; ack = 1'b1; tick(); ack = 1'b0;
    check_eq("late_ack_decode", 32'(state), 32'd2);
    check_eq("late_ack_no_trap", 32'(trap), 32'd0);

    // Illegal opcode traps; start is ignored there
    tick();
    check_eq("illegal_trap_state", 32'(state), 32'd6);
    check_eq("illegal_trap_ctl", 32'(ctl), 32'(pk(0,0,0,0,0,0,0,2'b00,2'b00,0,1)));
    start = 1'b1; tick(); tick();
    check_eq("trap_ignores_start", 32'(state), 32'd6);
    check_ret("trap_not_counted");
    start = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; ret_cnt = 0;
    check_eq("trap_reset_state", 32'(state), 32'd0);
    check_eq("trap_reset_ctl", 32'(ctl), 32'd0);
    check_ret("trap_reset_retired");

    // Fetch timeout with ack withheld
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check_eq("timeout_c15_state", 32'(state), 32'd1);
    tick();
    check_eq("timeout_trap_state", 32'(state), 32'd6);
    check_eq("timeout_trap_o", 32'(trap), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;

    // Reset mid-FETCH with a concurrent ack
    start = 1'b1; tick(); start = 1'b0;
    op = T_ADDI; ack = 1'b1; tick(); ack = 1'b0; tick(); tick(); tick(); ret_cnt = 1;
    check_ret("pre_reset_retired");
    rst = 1'b1; ack = 1'b1; #1;
    check_eq("ack_in_reset_irw", 32'({ir_write, pc_write}), 32'd0);
    tick(); rst = 1'b0; ack = 1'b0; ret_cnt = 0;
    check_eq("midfetch_reset_state", 32'(state), 32'd0);
    check_ret("midfetch_reset_retired");
    check_eq("midfetch_reset_ctl", 32'(ctl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
